// File: rtl/hssi_channel_fc_shim.sv
// AFU <-> HSSI channel shim: 2-entry TX skid slice with pause gating at packet
// boundaries, registered RX pass-through, registered pause/PFC and statistics.
module hssi_channel_fc_shim #(
  parameter int DATA_W = 64,
  parameter int USER_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  // AFU TX slave
  input  logic                afu_tx_tvalid,
  input  logic [DATA_W-1:0]   afu_tx_tdata,
  input  logic [DATA_W/8-1:0] afu_tx_tkeep,
  input  logic                afu_tx_tlast,
  input  logic [USER_W-1:0]   afu_tx_tuser,
  output logic                afu_tx_tready,
  // HSSI TX master
  output logic                hssi_tx_tvalid,
  output logic [DATA_W-1:0]   hssi_tx_tdata,
  output logic [DATA_W/8-1:0] hssi_tx_tkeep,
  output logic                hssi_tx_tlast,
  output logic [USER_W-1:0]   hssi_tx_tuser,
  input  logic                hssi_tx_tready,
  // HSSI RX input
  input  logic                hssi_rx_tvalid,
  input  logic [DATA_W-1:0]   hssi_rx_tdata,
  input  logic [DATA_W/8-1:0] hssi_rx_tkeep,
  input  logic                hssi_rx_tlast,
  input  logic [USER_W-1:0]   hssi_rx_tuser,
  // AFU RX output
  output logic                afu_rx_tvalid,
  output logic [DATA_W-1:0]   afu_rx_tdata,
  output logic [DATA_W/8-1:0] afu_rx_tkeep,
  output logic                afu_rx_tlast,
  output logic [USER_W-1:0]   afu_rx_tuser,
  // Flow control
  input  logic                afu_tx_pause,
  input  logic [7:0]          afu_tx_pfc,
  output logic                hssi_tx_pause,
  output logic [7:0]          hssi_tx_pfc,
  input  logic                hssi_rx_pause,
  input  logic [7:0]          hssi_rx_pfc,
  output logic                afu_rx_pause,
  output logic [7:0]          afu_rx_pfc,
  // Statistics
  output logic [31:0]         tx_pkt_cnt,
  output logic [31:0]         rx_pkt_cnt,
  output logic [31:0]         rx_byte_cnt
);

  localparam int KEEP_W = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

  state_t      state_q, state_d;
  logic        pause_q, pause_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  beat_t       out_q, out_d;
  beat_t       skid_q, skid_d;
  beat_t       afu_beat;
  logic        rx_valid_q, rx_valid_d;
  beat_t       rx_q, rx_d;
  logic        tx_pause_q, tx_pause_d;
  logic [7:0]  tx_pfc_q, tx_pfc_d;
  logic [7:0]  rx_pfc_q, rx_pfc_d;
  logic [31:0] tx_pkt_cnt_q, tx_pkt_cnt_d;
  logic [31:0] rx_pkt_cnt_q, rx_pkt_cnt_d;
  logic [31:0] rx_byte_cnt_q, rx_byte_cnt_d;
  logic [31:0] rx_keep_bytes;
  logic        tx_accept;
  logic        tx_drain;

  // Ready is built from flops only, so there is no combinational path from
  // hssi_tx_tready back to the AFU; a new packet may not start while paused.
  assign afu_tx_tready = rst_n & ~skid_valid_q & ~((state_q == ST_IDLE) & pause_q);
  assign tx_accept     = afu_tx_tvalid & afu_tx_tready;
  assign tx_drain      = out_valid_q & hssi_tx_tready;
  assign afu_beat      = '{data: afu_tx_tdata, keep: afu_tx_tkeep,
                           last: afu_tx_tlast, user: afu_tx_tuser};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_d         = out_q;
    skid_valid_d  = skid_valid_q;
    skid_d        = skid_q;
    rx_keep_bytes = '0;

    // Output register refills from the skid entry first to keep beat order.
    if (!out_valid_q || tx_drain) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_d       = afu_beat;
        out_valid_d = tx_accept;
      end
    end else if (tx_accept) begin
      skid_d       = afu_beat;
      skid_valid_d = 1'b1;
    end

    if (tx_accept) begin
      state_d = afu_tx_tlast ? ST_IDLE : ST_IN_PKT;
    end

    for (int i = 0; i < KEEP_W; i++) begin
      rx_keep_bytes = rx_keep_bytes + 32'(hssi_rx_tkeep[i]);
    end

    pause_d       = hssi_rx_pause;
    tx_pause_d    = afu_tx_pause;
    tx_pfc_d      = afu_tx_pfc;
    rx_pfc_d      = hssi_rx_pfc;
    rx_valid_d    = hssi_rx_tvalid;
    rx_d          = '{data: hssi_rx_tdata, keep: hssi_rx_tkeep,
                      last: hssi_rx_tlast, user: hssi_rx_tuser};
    tx_pkt_cnt_d  = tx_pkt_cnt_q + 32'(tx_drain & out_q.last);
    rx_pkt_cnt_d  = rx_pkt_cnt_q + 32'(hssi_rx_tvalid & hssi_rx_tlast);
    rx_byte_cnt_d = hssi_rx_tvalid ? rx_byte_cnt_q + rx_keep_bytes : rx_byte_cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pause_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_pause_q    <= 1'b0;
      tx_pfc_q      <= '0;
      rx_pfc_q      <= '0;
      tx_pkt_cnt_q  <= '0;
      rx_pkt_cnt_q  <= '0;
      rx_byte_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      pause_q       <= pause_d;
      out_valid_q   <= out_valid_d;
      skid_valid_q  <= skid_valid_d;
      rx_valid_q    <= rx_valid_d;
      tx_pause_q    <= tx_pause_d;
      tx_pfc_q      <= tx_pfc_d;
      rx_pfc_q      <= rx_pfc_d;
      tx_pkt_cnt_q  <= tx_pkt_cnt_d;
      rx_pkt_cnt_q  <= rx_pkt_cnt_d;
      rx_byte_cnt_q <= rx_byte_cnt_d;
    end
  end

  // NOTE: payload registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    out_q  <= out_d;
    skid_q <= skid_d;
    rx_q   <= rx_d;
  end

  assign hssi_tx_tvalid = out_valid_q;
  assign hssi_tx_tdata  = out_q.data;
  assign hssi_tx_tkeep  = out_q.keep;
  assign hssi_tx_tlast  = out_q.last;
  assign hssi_tx_tuser  = out_q.user;

  assign afu_rx_tvalid  = rx_valid_q;
  assign afu_rx_tdata   = rx_q.data;
  assign afu_rx_tkeep   = rx_q.keep;
  assign afu_rx_tlast   = rx_q.last;
  assign afu_rx_tuser   = rx_q.user;

  assign hssi_tx_pause  = tx_pause_q;
  assign hssi_tx_pfc    = tx_pfc_q;
  assign afu_rx_pause   = pause_q;
  assign afu_rx_pfc     = rx_pfc_q;

  assign tx_pkt_cnt     = tx_pkt_cnt_q;
  assign rx_pkt_cnt     = rx_pkt_cnt_q;
  assign rx_byte_cnt    = rx_byte_cnt_q;

endmodule

// File: tb/tb_hssi_channel_fc_shim.sv
// Bench for hssi_channel_fc_shim: queue-based channel model checked every cycle
// plus directed scenarios with literal expectations.
module tb_hssi_channel_fc_shim;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        afu_tx_tvalid, afu_tx_tlast, afu_tx_tready;
  logic [63:0] afu_tx_tdata;
  logic [7:0]  afu_tx_tkeep;
  logic [1:0]  afu_tx_tuser;
  logic        hssi_tx_tvalid, hssi_tx_tlast, hssi_tx_tready;
  logic [63:0] hssi_tx_tdata;
  logic [7:0]  hssi_tx_tkeep;
  logic [1:0]  hssi_tx_tuser;
  logic        hssi_rx_tvalid, hssi_rx_tlast;
  logic [63:0] hssi_rx_tdata;
  logic [7:0]  hssi_rx_tkeep;
  logic [1:0]  hssi_rx_tuser;
  logic        afu_rx_tvalid, afu_rx_tlast;
  logic [63:0] afu_rx_tdata;
  logic [7:0]  afu_rx_tkeep;
  logic [1:0]  afu_rx_tuser;
  logic        afu_tx_pause, hssi_tx_pause, hssi_rx_pause, afu_rx_pause;
  logic [7:0]  afu_tx_pfc, hssi_tx_pfc, hssi_rx_pfc, afu_rx_pfc;
  logic [31:0] tx_pkt_cnt, rx_pkt_cnt, rx_byte_cnt;

  hssi_channel_fc_shim dut (
    .clk(clk), .rst_n(rst_n),
    .afu_tx_tvalid(afu_tx_tvalid), .afu_tx_tdata(afu_tx_tdata), .afu_tx_tkeep(afu_tx_tkeep),
    .afu_tx_tlast(afu_tx_tlast), .afu_tx_tuser(afu_tx_tuser), .afu_tx_tready(afu_tx_tready),
    .hssi_tx_tvalid(hssi_tx_tvalid), .hssi_tx_tdata(hssi_tx_tdata), .hssi_tx_tkeep(hssi_tx_tkeep),
    .hssi_tx_tlast(hssi_tx_tlast), .hssi_tx_tuser(hssi_tx_tuser), .hssi_tx_tready(hssi_tx_tready),
    .hssi_rx_tvalid(hssi_rx_tvalid), .hssi_rx_tdata(hssi_rx_tdata), .hssi_rx_tkeep(hssi_rx_tkeep),
    .hssi_rx_tlast(hssi_rx_tlast), .hssi_rx_tuser(hssi_rx_tuser),
    .afu_rx_tvalid(afu_rx_tvalid), .afu_rx_tdata(afu_rx_tdata), .afu_rx_tkeep(afu_rx_tkeep),
    .afu_rx_tlast(afu_rx_tlast), .afu_rx_tuser(afu_rx_tuser),
    .afu_tx_pause(afu_tx_pause), .afu_tx_pfc(afu_tx_pfc),
    .hssi_tx_pause(hssi_tx_pause), .hssi_tx_pfc(hssi_tx_pfc),
    .hssi_rx_pause(hssi_rx_pause), .hssi_rx_pfc(hssi_rx_pfc),
    .afu_rx_pause(afu_rx_pause), .afu_rx_pfc(afu_rx_pfc),
    .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .rx_byte_cnt(rx_byte_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  user;
  } beat_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channel model: the slice is a FIFO of accepted-but-undelivered beats that
  // may never hold more than two; everything else is "previous cycle's input".
  beat_t       m_txq[$];
  beat_t       got_tx[$];
  int          got_cyc[$];
  int          acc_cyc[$];
  logic        known = 1'b0;
  logic        m_in_pkt, m_pause, m_tx_pause;
  logic [7:0]  m_tx_pfc, m_rx_pfc;
  logic        m_rx_valid;
  beat_t       m_rx;
  logic [31:0] m_tx_pkts, m_rx_pkts, m_rx_bytes;
  logic        exp_rdy;
  int          cyc = 0;
  int          preload_seq = 0;
  int          preload_seen = 0;
  logic [31:0] preload_val = '0;

  always @(negedge clk) begin
    cyc++;
    if (preload_seq != preload_seen) begin
      preload_seen = preload_seq;
      m_rx_bytes   = preload_val;
    end
    exp_rdy = rst_n && (m_txq.size() < 2) && !(!m_in_pkt && m_pause);
    if (known) begin
      check("afu_tx_tready", afu_tx_tready, exp_rdy);
      check("hssi_tx_tvalid", hssi_tx_tvalid, m_txq.size() != 0);
      if (m_txq.size() != 0) begin
        check("hssi_tx_tdata", hssi_tx_tdata, m_txq[0].data);
        check("hssi_tx_tkeep", hssi_tx_tkeep, m_txq[0].keep);
        check("hssi_tx_tlast", hssi_tx_tlast, m_txq[0].last);
        check("hssi_tx_tuser", hssi_tx_tuser, m_txq[0].user);
      end
      check("afu_rx_tvalid", afu_rx_tvalid, m_rx_valid);
      if (m_rx_valid) begin
        check("afu_rx_tdata", afu_rx_tdata, m_rx.data);
        check("afu_rx_tkeep", afu_rx_tkeep, m_rx.keep);
        check("afu_rx_tlast", afu_rx_tlast, m_rx.last);
        check("afu_rx_tuser", afu_rx_tuser, m_rx.user);
      end
      check("hssi_tx_pause", hssi_tx_pause, m_tx_pause);
      check("hssi_tx_pfc", hssi_tx_pfc, m_tx_pfc);
      check("afu_rx_pause", afu_rx_pause, m_pause);
      check("afu_rx_pfc", afu_rx_pfc, m_rx_pfc);
      check("tx_pkt_cnt", tx_pkt_cnt, m_tx_pkts);
      check("rx_pkt_cnt", rx_pkt_cnt, m_rx_pkts);
      check("rx_byte_cnt", rx_byte_cnt, m_rx_bytes);
    end
    if (!rst_n) begin
      m_txq.delete();
      m_in_pkt = 0; m_pause = 0; m_tx_pause = 0;
      m_tx_pfc = '0; m_rx_pfc = '0; m_rx_valid = 0;
      m_tx_pkts = '0; m_rx_pkts = '0; m_rx_bytes = '0;
      known = 1'b1;
    end else if (known) begin
      if (m_txq.size() != 0 && hssi_tx_tready) begin
        got_tx.push_back('{hssi_tx_tdata, hssi_tx_tkeep, hssi_tx_tlast, hssi_tx_tuser});
        got_cyc.push_back(cyc);
        if (m_txq[0].last) m_tx_pkts = m_tx_pkts + 1;
        void'(m_txq.pop_front());
      end
      if (afu_tx_tvalid && exp_rdy) begin
        m_txq.push_back('{afu_tx_tdata, afu_tx_tkeep, afu_tx_tlast, afu_tx_tuser});
        acc_cyc.push_back(cyc);
        m_in_pkt = !afu_tx_tlast;
      end
      m_pause    = hssi_rx_pause;
      m_tx_pause = afu_tx_pause;
      m_tx_pfc   = afu_tx_pfc;
      m_rx_pfc   = hssi_rx_pfc;
      m_rx_valid = hssi_rx_tvalid;
      m_rx       = '{hssi_rx_tdata, hssi_rx_tkeep, hssi_rx_tlast, hssi_rx_tuser};
      if (hssi_rx_tvalid) begin
        m_rx_bytes = m_rx_bytes + 32'($countones(hssi_rx_tkeep));
        if (hssi_rx_tlast) m_rx_pkts = m_rx_pkts + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns just after that edge.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [1:0] u);
    int n = 0;
    afu_tx_tvalid = 1'b1;
    afu_tx_tdata  = d;
    afu_tx_tkeep  = k;
    afu_tx_tlast  = l;
    afu_tx_tuser  = u;
    @(negedge clk);
    while (!afu_tx_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: beat %h never accepted, waited %0d cycles", d, n);
    end
    step();
    afu_tx_tvalid = 1'b0;
  endtask

  int g0, a0;

  initial begin
    rst_n = 0;
    afu_tx_tvalid = 0; afu_tx_tdata = '0; afu_tx_tkeep = '0; afu_tx_tlast = 0; afu_tx_tuser = '0;
    hssi_tx_tready = 1;
    hssi_rx_tvalid = 0; hssi_rx_tdata = '0; hssi_rx_tkeep = '0; hssi_rx_tlast = 0; hssi_rx_tuser = '0;
    afu_tx_pause = 0; afu_tx_pfc = '0; hssi_rx_pause = 0; hssi_rx_pfc = '0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_tready_low", afu_tx_tready, 1'b0);
    check("rst_tx_valid", hssi_tx_tvalid, 1'b0);
    check("rst_rx_bytes", rx_byte_cnt, 32'd0);
    step();
    rst_n = 1;
    @(negedge clk);
    check("post_rst_tready", afu_tx_tready, 1'b1);
    step();

    // Back-to-back 3-beat packet
    g0 = got_tx.size(); a0 = acc_cyc.size();
    send(64'h11, 8'hFF, 0, 2'd1);
    send(64'h22, 8'hFF, 0, 2'd2);
    send(64'h33, 8'hFF, 1, 2'd3);
    repeat (3) step();
    check("b2b_count", got_tx.size() - g0, 3);
    check("b2b_beat0", got_tx[g0].data, 64'h11);
    check("b2b_beat1", got_tx[g0+1].data, 64'h22);
    check("b2b_beat2", got_tx[g0+2].data, 64'h33);
    check("b2b_user2", got_tx[g0+2].user, 2'd3);
    check("b2b_latency", got_cyc[g0] - acc_cyc[a0], 1);
    check("b2b_rate01", got_cyc[g0+1] - got_cyc[g0], 1);
    check("b2b_rate12", got_cyc[g0+2] - got_cyc[g0+1], 1);
    check("b2b_pkt_cnt", tx_pkt_cnt, 32'd1);

    // Backpressure for 5 cycles mid-packet
    g0 = got_tx.size();
    hssi_tx_tready = 0;
    fork
      begin
        send(64'hA1, 8'hFF, 0, 2'd0);
        send(64'hA2, 8'h0F, 0, 2'd1);
        send(64'hA3, 8'hF0, 0, 2'd2);
        send(64'hA4, 8'h01, 1, 2'd3);
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_tready_low", afu_tx_tready, 1'b0);
        check("bp_hold_data", hssi_tx_tdata, 64'hA1);
        check("bp_hold_valid", hssi_tx_tvalid, 1'b1);
        step();
        hssi_tx_tready = 1;
      end
    join
    repeat (4) step();
    check("bp_count", got_tx.size() - g0, 4);
    check("bp_beat1", got_tx[g0+1].data, 64'hA2);
    check("bp_beat3", got_tx[g0+3].data, 64'hA4);
    check("bp_keep2", got_tx[g0+2].keep, 8'hF0);
    check("bp_pkt_cnt", tx_pkt_cnt, 32'd2);

    // Pause mid-packet: packet completes, next packet waits for pause release
    send(64'hB1, 8'hFF, 0, 2'd0);
    hssi_rx_pause = 1;
    send(64'hB2, 8'hFF, 0, 2'd0);
    send(64'hB3, 8'hFF, 1, 2'd0);
    fork
      send(64'hC1, 8'hFF, 1, 2'd1);
      begin
        repeat (3) @(negedge clk);
        check("pause_tready_low", afu_tx_tready, 1'b0);
        check("pause_afu_rx", afu_rx_pause, 1'b1);
        step();
        hssi_rx_pause = 0;
      end
    join
    repeat (3) step();
    check("pause_pkt_cnt", tx_pkt_cnt, 32'd4);

    // RX 2-beat packet
    hssi_rx_tvalid = 1; hssi_rx_tdata = 64'h0123_4567_89AB_CDEF; hssi_rx_tkeep = 8'hFF;
    hssi_rx_tlast = 0; hssi_rx_tuser = 2'd2;
    step();
    hssi_rx_tdata = 64'hFEDC_BA98_7654_3210; hssi_rx_tkeep = 8'h0F; hssi_rx_tlast = 1;
    step();
    hssi_rx_tvalid = 0;
    @(negedge clk);
    check("rx_mirror_data", afu_rx_tdata, 64'hFEDC_BA98_7654_3210);
    check("rx_mirror_keep", afu_rx_tkeep, 8'h0F);
    check("rx_mirror_last", afu_rx_tlast, 1'b1);
    check("rx_pkts", rx_pkt_cnt, 32'd1);
    check("rx_bytes", rx_byte_cnt, 32'd12);
    step();

    // Byte counter wrap
    preload_val = 32'hFFFF_FFFC;
    preload_seq++;
    force dut.rx_byte_cnt_q = 32'hFFFF_FFFC;
    step();
    release dut.rx_byte_cnt_q;
    hssi_rx_tvalid = 1; hssi_rx_tkeep = 8'hFF; hssi_rx_tlast = 1;
    step();
    hssi_rx_tvalid = 0;
    @(negedge clk);
    check("rx_bytes_wrap", rx_byte_cnt, 32'd4);
    check("rx_pkts_after_wrap", rx_pkt_cnt, 32'd2);
    step();

    // Flow-control pass-through
    afu_tx_pfc = 8'hA5; afu_tx_pause = 1; hssi_rx_pfc = 8'h3C;
    step();
    @(negedge clk);
    check("fc_tx_pfc", hssi_tx_pfc, 8'hA5);
    check("fc_tx_pause", hssi_tx_pause, 1'b1);
    check("fc_rx_pfc", afu_rx_pfc, 8'h3C);
    step();

    // Reset mid-packet with beats buffered
    hssi_tx_tready = 0;
    send(64'hD1, 8'hFF, 0, 2'd0);
    send(64'hD2, 8'hFF, 0, 2'd0);
    rst_n = 0;
    repeat (2) step();
    @(negedge clk);
    check("mid_rst_tx_valid", hssi_tx_tvalid, 1'b0);
    check("mid_rst_rx_valid", afu_rx_tvalid, 1'b0);
    check("mid_rst_tx_cnt", tx_pkt_cnt, 32'd0);
    check("mid_rst_rx_cnt", rx_pkt_cnt, 32'd0);
    check("mid_rst_bytes", rx_byte_cnt, 32'd0);
    check("mid_rst_pfc", hssi_tx_pfc, 8'h00);
    step();
    rst_n = 1;
    hssi_tx_tready = 1;
    g0 = got_tx.size();
    send(64'hE1, 8'hFF, 0, 2'd1);
    send(64'hE2, 8'h3F, 1, 2'd2);
    repeat (3) step();
    check("fresh_count", got_tx.size() - g0, 2);
    check("fresh_beat0", got_tx[g0].data, 64'hE1);
    check("fresh_beat1", got_tx[g0+1].data, 64'hE2);
    check("fresh_pkt_cnt", tx_pkt_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hssi_channel_fc_shim.md
HSSI_CHANNEL_FC_SHIM -- requirements
Module: hssi_channel_fc_shim

Interface
REQ-001 The module SHALL have parameter DATA_W, default 64, TDATA width in bits; legal values are multiples of 8.
REQ-002 The module SHALL have parameter USER_W, default 2, TUSER width in bits.
REQ-003 The module SHALL have the following ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, synchronous, active-low.
REQ-004 The module SHALL have the following AFU TX slave ports:
- afu_tx_tvalid  in  1
- afu_tx_tdata  in  DATA_W
- afu_tx_tkeep  in  DATA_W/8
- afu_tx_tlast  in  1
- afu_tx_tuser  in  USER_W
- afu_tx_tready  out  1
REQ-005 The module SHALL have the following HSSI TX master ports:
- hssi_tx_tvalid  out  1
- hssi_tx_tdata  out  DATA_W
- hssi_tx_tkeep  out  DATA_W/8
- hssi_tx_tlast  out  1
- hssi_tx_tuser  out  USER_W
- hssi_tx_tready  in  1
REQ-006 The module SHALL have the following HSSI RX input ports, with no ready signal:
- hssi_rx_tvalid  in  1
- hssi_rx_tdata  in  DATA_W
- hssi_rx_tkeep  in  DATA_W/8
- hssi_rx_tlast  in  1
- hssi_rx_tuser  in  USER_W
REQ-007 The module SHALL have AFU RX output ports afu_rx_tvalid, afu_rx_tdata, afu_rx_tkeep, afu_rx_tlast and afu_rx_tuser, with the same widths as the HSSI RX inputs.
REQ-008 The module SHALL have the following flow-control ports:
- afu_tx_pause  in  1  AFU request for the MAC to send pause frames.
- afu_tx_pfc  in  8  AFU per-priority pause request.
- hssi_tx_pause  out  1
- hssi_tx_pfc  out  8
- hssi_rx_pause  in  1  link partner pause received.
- hssi_rx_pfc  in  8  received per-priority pause.
- afu_rx_pause  out  1
- afu_rx_pfc  out  8
REQ-009 The module SHALL have the following statistics ports:
- tx_pkt_cnt  out  32  packets sent.
- rx_pkt_cnt  out  32  packets received.
- rx_byte_cnt  out  32  bytes received.

Function
REQ-010 The TX path SHALL be a 2-entry skid register slice: full throughput, hssi_tx_* registered, afu_tx_tready registered and high while at least 1 entry is free.
REQ-011 A beat SHALL transfer on each side only when valid and ready are both 1.
REQ-012 TX data, keep, last and user SHALL be preserved in order, with no reordering, duplication or loss.
REQ-013 TX latency from AFU accept to hssi_tx_tvalid SHALL be 1 cycle when the slice is empty.
REQ-014 hssi_tx_tvalid SHALL stay asserted and hssi_tx_* SHALL hold stable until hssi_tx_tready=1.
REQ-015 The TX pause gate SHALL use a 2-state FSM at the AFU input:
- IDLE to IN_PKT on an accepted beat with tlast=0.
- IN_PKT to IDLE on an accepted beat with tlast=1.
- A single-beat packet (tlast=1 in IDLE) keeps the FSM in IDLE.
REQ-016 In IDLE with pause_q=1, afu_tx_tready SHALL be 0, so no new packet starts; pause_q is hssi_rx_pause registered once.
REQ-017 In IN_PKT, pause SHALL be ignored so that an in-flight packet always completes.
REQ-018 When pause_q deasserts, accepts SHALL resume on the next cycle.
REQ-019 The RX path SHALL be a registered pass-through: afu_rx_* equals hssi_rx_* delayed by exactly 1 cycle.
REQ-020 afu_rx_tdata, tkeep, tlast and tuser SHALL be don't-care when afu_rx_tvalid=0.
REQ-021 The flow-control signals SHALL each be registered once, 1-cycle latency:
- hssi_tx_pause = afu_tx_pause
- hssi_tx_pfc = afu_tx_pfc
- afu_rx_pause = hssi_rx_pause
- afu_rx_pfc = hssi_rx_pfc
REQ-022 tx_pkt_cnt SHALL increment by 1 on each hssi_tx beat with tvalid, tready and tlast all 1.
REQ-023 rx_pkt_cnt SHALL increment by 1 on each hssi_rx beat with tvalid=1 and tlast=1.
REQ-024 rx_byte_cnt SHALL add popcount(hssi_rx_tkeep) on each hssi_rx beat with tvalid=1.
REQ-025 All counters SHALL be modulo 2^32, wrapping silently from 0xFFFFFFFF to 0.
REQ-026 All counters SHALL update 1 cycle after the qualifying beat.
REQ-027 A simultaneous TX accept and TX drain in the same cycle SHALL keep occupancy unchanged and sustain full rate.

Reset
REQ-028 rst_n=0 sampled at a clk edge SHALL clear the following:
- hssi_tx_tvalid, afu_rx_tvalid
- all pause and pfc outputs
- all counters
- FSM to IDLE
- skid buffer to empty
REQ-029 afu_tx_tready SHALL be 0 while rst_n=0, and 1 in the first cycle after release if pause_q=0.
REQ-030 Data-path registers SHALL need no reset.
REQ-031 Reset asserted mid-packet SHALL discard buffered beats; after release, no partial packet is emitted and the FSM starts in IDLE.

Verification
REQ-032 Back-to-back TX with hssi_tx_tready=1: send a 3-beat packet of data 0x11, 0x22, 0x33 -> same beats out 1 cycle later, 1 beat per cycle, tx_pkt_cnt=1.
REQ-033 TX backpressure: hold hssi_tx_tready=0 for 5 cycles during a packet -> at most 2 beats are buffered, then afu_tx_tready=0, hssi_tx_* held stable, and no beat is lost once tready returns.
REQ-034 Pause: assert hssi_rx_pause mid-packet -> the packet completes, and the next packet's first beat is not accepted until pause is low for 1 cycle.
REQ-035 RX: a 2-beat packet with tkeep 0xFF then 0x0F -> afu_rx mirrors it 1 cycle later, rx_pkt_cnt=1, rx_byte_cnt=12.
REQ-036 Wrap: preload or drive rx_byte_cnt to 0xFFFFFFFC, then receive a beat with tkeep 0xFF -> rx_byte_cnt=4.
REQ-037 Flow-control pass-through plus reset: afu_tx_pfc=0xA5 gives hssi_tx_pfc=0xA5 next cycle; reset mid-packet clears all valids and counters, and the following fresh packet passes intact.
